// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment pattern constants, digit type and frame FSM states shared by the monitor
package seg_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    IDLE,
    COLLECT
  } frame_state_e;

  // Active-low CA..CG patterns as driven by the display scanner
  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - maps a 7-bit active-low segment pattern to {legal, blank, code}
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       legal_o,
  output logic       blank_o,
  output digit_t     code_o
);

  always_comb begin
    legal_o = 1'b1;
    blank_o = 1'b0;
    code_o  = 4'h0;
    case (pattern_i)
      SEG_HEX_0: code_o = 4'h0;
      SEG_HEX_1: code_o = 4'h1;
      SEG_HEX_2: code_o = 4'h2;
      SEG_HEX_3: code_o = 4'h3;
      SEG_HEX_4: code_o = 4'h4;
      SEG_HEX_5: code_o = 4'h5;
      SEG_HEX_6: code_o = 4'h6;
      SEG_HEX_7: code_o = 4'h7;
      SEG_HEX_8: code_o = 4'h8;
      SEG_HEX_9: code_o = 4'h9;
      SEG_HEX_A: code_o = 4'hA;
      SEG_HEX_B: code_o = 4'hB;
      SEG_HEX_C: code_o = 4'hC;
      SEG_HEX_D: code_o = 4'hD;
      SEG_HEX_E: code_o = 4'hE;
      SEG_HEX_F: code_o = 4'hF;
      SEG_BLANK: begin
        legal_o = 1'b0;
        blank_o = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_display_monitor.sv
// rtl/seg_display_monitor.sv - filters and decodes a multiplexed 4-digit seven-segment bus into frames
// Optional SEG_DP_CAPTURE_EN adds the dp output capturing each position's decimal point.
module seg_display_monitor
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [7:0]  seven_seg,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        frame_timeout,
  output logic        seg_err,
  output logic        an_err
`ifdef SEG_DP_CAPTURE_EN
  ,
  output logic [3:0]  dp
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [3:0]       an_q, an_prev_q;
  logic [6:0]       seg_q, seg_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sample_same, dwell_done;

  logic       an_one_hot, an_idle, commit;
  logic [1:0] pos;

  logic   dec_legal, dec_blank;
  digit_t dec_code;

  frame_state_e     state_q, state_d;
  logic [3:0]       seen_q, seen_d, seen_upd;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       valid_q, valid_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_timeout_q, frame_timeout_d;
  logic             seg_err_q, seg_err_d;
  logic             an_err_q, an_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q       <= 4'h0;
      seg_q      <= 7'h0;
      an_prev_q  <= 4'h0;
      seg_prev_q <= 7'h0;
      cnt_q      <= '0;
    end else begin
      an_q       <= an;
      seg_q      <= seven_seg[6:0];
      an_prev_q  <= an_q;
      seg_prev_q <= seg_q;
      cnt_q      <= cnt_d;
    end
  end

  // Saturating dwell counter: exactly one dwell_done per stable period
  assign sample_same = ({an_q, seg_q} == {an_prev_q, seg_prev_q});

  always_comb begin
    cnt_d = cnt_q;
    if (!sample_same) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign dwell_done = sample_same && (cnt_q == CNT_LAST);

  always_comb begin
    an_one_hot = 1'b1;
    pos        = 2'd0;
    case (an_q)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: an_one_hot = 1'b0;
    endcase
  end

  assign an_idle = (an_q == 4'b1111);
  assign commit  = dwell_done && an_one_hot;

  seg_pattern_decode u_decode (
    .pattern_i (seg_q),
    .legal_o   (dec_legal),
    .blank_o   (dec_blank),
    .code_o    (dec_code)
  );

  always_comb begin
    state_d         = state_q;
    seen_d          = seen_q;
    timer_d         = timer_q;
    digits_d        = digits_q;
    valid_d         = valid_q;
    frame_valid_d   = 1'b0;
    frame_timeout_d = 1'b0;
    seg_err_d       = seg_err_q;
    an_err_d        = an_err_q;
    seen_upd        = seen_q | (4'b0001 << pos);

    if (commit) begin
      digits_d[{pos, 2'b00} +: 4] = dec_code;
      valid_d[pos]                = dec_legal;
      if (!dec_legal && !dec_blank) begin
        seg_err_d = 1'b1;
      end
    end

    if (dwell_done && !an_one_hot && !an_idle) begin
      an_err_d = 1'b1;
    end

    // A commit always takes priority over an expiring timer
    case (state_q)
      IDLE: begin
        if (commit) begin
          state_d = COLLECT;
          timer_d = '0;
          seen_d  = seen_upd;
        end
      end
      COLLECT: begin
        if (commit) begin
          timer_d = '0;
          if (seen_upd == 4'hF) begin
            frame_valid_d = 1'b1;
            seen_d        = 4'h0;
            state_d       = IDLE;
          end else begin
            seen_d = seen_upd;
          end
        end else if (timer_q == TMR_LAST) begin
          frame_timeout_d = 1'b1;
          seen_d          = 4'h0;
          state_d         = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      seen_q          <= 4'h0;
      timer_q         <= '0;
      digits_q        <= 16'h0;
      valid_q         <= 4'h0;
      frame_valid_q   <= 1'b0;
      frame_timeout_q <= 1'b0;
      seg_err_q       <= 1'b0;
      an_err_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      seen_q          <= seen_d;
      timer_q         <= timer_d;
      digits_q        <= digits_d;
      valid_q         <= valid_d;
      frame_valid_q   <= frame_valid_d;
      frame_timeout_q <= frame_timeout_d;
      seg_err_q       <= seg_err_d;
      an_err_q        <= an_err_d;
    end
  end

  assign digits        = digits_q;
  assign digit_valid   = valid_q;
  assign frame_valid   = frame_valid_q;
  assign frame_timeout = frame_timeout_q;
  assign seg_err       = seg_err_q;
  assign an_err        = an_err_q;

`ifdef SEG_DP_CAPTURE_EN
  logic       dp_in_q;
  logic [3:0] dp_q, dp_d;

  always_comb begin
    dp_d = dp_q;
    if (commit) begin
      dp_d[pos] = ~dp_in_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_in_q <= 1'b1;
      dp_q    <= 4'h0;
    end else begin
      dp_in_q <= seven_seg[7];
      dp_q    <= dp_d;
    end
  end

  assign dp = dp_q;
`else
  logic unused_dp;
  assign unused_dp = seven_seg[7];
`endif

endmodule
